code_patch_arb: RTL and testbench

- Controller and arbiter for the code-patch table: a 3-entry × 22-bit register array holding patch entries.
- Shares table lookups between two requesters: the serial-interface read path (si) and the pattern generator (pg, gated by cfg_pat_gen_i).
- Table is written through a config port; each lookup returns a hit flag and a patch byte.
- Sits between the serial interface/pattern generator and the patch datapath.

---
 rtl/code_patch_arb.sv | 158 +++++++++++++++
 tb/tb_code_patch_arb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_patch_arb.sv
// Code-patch table controller: a small register table written through a config port,
// with lookups shared between the serial interface (si) and pattern generator (pg) requesters.
module code_patch_arb #(
    parameter int NUM_ENTRIES = 3,
    parameter int DATA_W      = 22,
    parameter int ADDR_W      = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_idx_i,
    input  logic [DATA_W-1:0] cfg_wdata_i,
    input  logic              cfg_pat_gen_i,
    input  logic              si_req_i,
    input  logic [ADDR_W-1:0] si_addr_i,
    output logic              si_gnt_o,
    output logic              si_rvalid_o,
    output logic              si_hit_o,
    output logic [7:0]        si_data_o,
    input  logic              pg_req_i,
    input  logic [ADDR_W-1:0] pg_addr_i,
    output logic              pg_gnt_o,
    output logic              pg_rvalid_o,
    output logic              pg_hit_o,
    output logic [7:0]        pg_data_o,
    output logic              patch_enable_o,
    output logic              nopg_o
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

    localparam logic [1:0] LAST_IDX = 2'(NUM_ENTRIES - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   table_q [NUM_ENTRIES];
    logic [DATA_W-1:0]   table_d [NUM_ENTRIES];
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                tag_pg_q, tag_pg_d;
    logic                prio_pg_q, prio_pg_d;
    logic                si_rvalid_q, si_rvalid_d, si_hit_q, si_hit_d;
    logic                pg_rvalid_q, pg_rvalid_d, pg_hit_q, pg_hit_d;
    logic [7:0]          si_data_q, si_data_d, pg_data_q, pg_data_d;
    logic                patch_en_q, patch_en_d, nopg_q, nopg_d;

    logic                eff_pg_req;
    logic                si_gnt, pg_gnt;
    logic                lk_hit;
    logic [7:0]          lk_data;

    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        addr_d      = addr_q;
        tag_pg_d    = tag_pg_q;
        prio_pg_d   = prio_pg_q;
        si_rvalid_d = 1'b0;
        si_hit_d    = si_hit_q;
        si_data_d   = si_data_q;
        pg_rvalid_d = 1'b0;
        pg_hit_d    = pg_hit_q;
        pg_data_d   = pg_data_q;
        si_gnt      = 1'b0;
        pg_gnt      = 1'b0;
        lk_hit      = 1'b0;
        lk_data     = 8'h00;

        eff_pg_req = pg_req_i & cfg_pat_gen_i;

        // prio_pg_q set means pg was not the last winner, so it takes the next tie.
        if (state_q == IDLE && !rst_i) begin
            if (si_req_i && (!eff_pg_req || !prio_pg_q)) si_gnt = 1'b1;
            else if (eff_pg_req)                          pg_gnt = 1'b1;
        end

        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (table_q[i][DATA_W-1] && table_q[i][DATA_W-2:8] == addr_q) begin
                lk_hit  = 1'b1;
                lk_data = table_q[i][7:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (si_gnt || pg_gnt) begin
                    addr_d    = pg_gnt ? pg_addr_i : si_addr_i;
                    tag_pg_d  = pg_gnt;
                    prio_pg_d = si_gnt;
                    state_d   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (tag_pg_q) begin
                    pg_rvalid_d = 1'b1;
                    pg_hit_d    = lk_hit;
                    pg_data_d   = lk_data;
                end else begin
                    si_rvalid_d = 1'b1;
                    si_hit_d    = lk_hit;
                    si_data_d   = lk_data;
                end
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase

        if (cfg_we_i && cfg_idx_i <= LAST_IDX) table_d[cfg_idx_i] = cfg_wdata_i;

        patch_en_d = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) patch_en_d = patch_en_d | table_q[i][DATA_W-1];
        nopg_d = ~cfg_pat_gen_i | ~patch_en_d;
    end

    // NOTE: the table is a handful of flops that must read as all-miss after reset, so it is reset like any other register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
            addr_q      <= '0;
            tag_pg_q    <= 1'b0;
            prio_pg_q   <= 1'b0;
            si_rvalid_q <= 1'b0;
            si_hit_q    <= 1'b0;
            si_data_q   <= 8'h00;
            pg_rvalid_q <= 1'b0;
            pg_hit_q    <= 1'b0;
            pg_data_q   <= 8'h00;
            patch_en_q  <= 1'b0;
            nopg_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            addr_q      <= addr_d;
            tag_pg_q    <= tag_pg_d;
            prio_pg_q   <= prio_pg_d;
            si_rvalid_q <= si_rvalid_d;
            si_hit_q    <= si_hit_d;
            si_data_q   <= si_data_d;
            pg_rvalid_q <= pg_rvalid_d;
            pg_hit_q    <= pg_hit_d;
            pg_data_q   <= pg_data_d;
            patch_en_q  <= patch_en_d;
            nopg_q      <= nopg_d;
        end
    end

    assign si_gnt_o       = si_gnt;
    assign pg_gnt_o       = pg_gnt;
    assign si_rvalid_o    = si_rvalid_q;
    assign si_hit_o       = si_hit_q;
    assign si_data_o      = si_data_q;
    assign pg_rvalid_o    = pg_rvalid_q;
    assign pg_hit_o       = pg_hit_q;
    assign pg_data_o      = pg_data_q;
    assign patch_enable_o = patch_en_q;
    assign nopg_o         = nopg_q;

endmodule

// File: tb/tb_code_patch_arb.sv
// Self-checking bench for code_patch_arb: directed scenarios then random traffic,
// compared against a timestamp-based transaction model of the arbiter and table.
module tb_code_patch_arb;

    logic        clk_i = 1'b0;
    logic        rst_i, cfg_we_i, cfg_pat_gen_i;
    logic [1:0]  cfg_idx_i;
    logic [21:0] cfg_wdata_i;
    logic        si_req_i, si_gnt_o, si_rvalid_o, si_hit_o;
    logic [12:0] si_addr_i, pg_addr_i;
    logic [7:0]  si_data_o, pg_data_o;
    logic        pg_req_i, pg_gnt_o, pg_rvalid_o, pg_hit_o;
    logic        patch_enable_o, nopg_o;

    always #5 clk_i = ~clk_i;

    code_patch_arb dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_pat_gen_i(cfg_pat_gen_i),
        .si_req_i(si_req_i), .si_addr_i(si_addr_i), .si_gnt_o(si_gnt_o),
        .si_rvalid_o(si_rvalid_o), .si_hit_o(si_hit_o), .si_data_o(si_data_o),
        .pg_req_i(pg_req_i), .pg_addr_i(pg_addr_i), .pg_gnt_o(pg_gnt_o),
        .pg_rvalid_o(pg_rvalid_o), .pg_hit_o(pg_hit_o), .pg_data_o(pg_data_o),
        .patch_enable_o(patch_enable_o), .nopg_o(nopg_o)
    );

    typedef struct {
        bit          rst, we, pat, sreq, preq;
        logic [1:0]  idx;
        logic [21:0] wd;
        logic [12:0] saddr, paddr;
    } stim_t;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction model: cycle stamps for when the port is free and when the pending lookup resolves.
    logic [21:0] m_tab [3];
    int          cyc, free_cyc, p_due;
    bit          si_next, p_valid, p_pg, r_hit, exp_pe, exp_nopg;
    logic [12:0] p_addr;
    logic [7:0]  r_data;
    stim_t       s;
    int          grant_count;

    function automatic void m_lookup(input logic [12:0] a, output bit hit, output logic [7:0] d);
        hit = 1'b0;
        d   = 8'h00;
        for (int i = 0; i < 3; i++)
            if (!hit && m_tab[i][21] && m_tab[i][20:8] == a) begin
                hit = 1'b1;
                d   = m_tab[i][7:0];
            end
    endfunction

    function automatic logic [21:0] entry(input bit en, input logic [12:0] a, input logic [7:0] b);
        return {en, a, b};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_tab[i] = '0;
        si_next  = 1'b1;
        p_valid  = 1'b0;
        exp_pe   = 1'b0;
        exp_nopg = 1'b1;
        r_hit    = 1'b0;
        r_data   = 8'h00;
        free_cyc = cyc + 1;
    endtask

    task automatic step();
        bit exp_sg, exp_pg, eff_pg, any_en;
        @(negedge clk_i);
        rst_i = s.rst; cfg_we_i = s.we; cfg_idx_i = s.idx; cfg_wdata_i = s.wd;
        cfg_pat_gen_i = s.pat; si_req_i = s.sreq; si_addr_i = s.saddr;
        pg_req_i = s.preq; pg_addr_i = s.paddr;
        #1;
        if (s.rst) begin
            check("rst_si_gnt", si_gnt_o, 0);
            check("rst_pg_gnt", pg_gnt_o, 0);
            check("rst_si_rvalid", si_rvalid_o, 0);
            check("rst_pg_rvalid", pg_rvalid_o, 0);
            check("rst_hit_data", {si_hit_o, si_data_o, pg_hit_o, pg_data_o}, 0);
            check("rst_patch_en", patch_enable_o, 0);
            check("rst_nopg", nopg_o, 1);
            m_reset();
        end else begin
            if (p_valid && p_due == cyc + 1) m_lookup(p_addr, r_hit, r_data);
            check("si_rvalid", si_rvalid_o, p_valid && p_due == cyc && !p_pg);
            check("pg_rvalid", pg_rvalid_o, p_valid && p_due == cyc && p_pg);
            if (p_valid && p_due == cyc) begin
                if (p_pg) check("pg_resp", {pg_hit_o, pg_data_o}, {r_hit, r_data});
                else      check("si_resp", {si_hit_o, si_data_o}, {r_hit, r_data});
                p_valid = 1'b0;
            end
            check("patch_en", patch_enable_o, exp_pe);
            check("nopg", nopg_o, exp_nopg);

            eff_pg = s.preq && s.pat;
            exp_sg = 1'b0;
            exp_pg = 1'b0;
            if (cyc >= free_cyc) begin
                if (s.sreq && eff_pg) begin
                    exp_sg = si_next;
                    exp_pg = !si_next;
                end else begin
                    exp_sg = s.sreq;
                    exp_pg = eff_pg;
                end
            end
            check("si_gnt", si_gnt_o, exp_sg);
            check("pg_gnt", pg_gnt_o, exp_pg);
            if (exp_sg || exp_pg) begin
                grant_count++;
                si_next  = exp_pg;
                p_valid  = 1'b1;
                p_pg     = exp_pg;
                p_addr   = exp_pg ? s.paddr : s.saddr;
                p_due    = cyc + 2;
                free_cyc = cyc + 3;
            end

            any_en   = m_tab[0][21] || m_tab[1][21] || m_tab[2][21];
            exp_pe   = any_en;
            exp_nopg = !s.pat || !any_en;
            if (s.we && s.idx != 2'd3) m_tab[s.idx] = s.wd;
        end
        cyc++;
        s.we  = 1'b0;
        s.rst = 1'b0;
    endtask

    task automatic idle(input int n);
        s.sreq = 1'b0;
        s.preq = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] idx, input logic [21:0] wd);
        s.we  = 1'b1;
        s.idx = idx;
        s.wd  = wd;
        step();
    endtask

    task automatic si_lookup(input logic [12:0] a);
        s.sreq  = 1'b1;
        s.saddr = a;
        step();
        s.sreq = 1'b0;
        step();
        step();
    endtask

    logic [12:0] pool [4];

    initial begin
        cyc = 0;
        grant_count = 0;
        s = '{rst: 1'b1, we: 1'b0, pat: 1'b1, sreq: 1'b0, preq: 1'b0,
              idx: 2'd0, wd: '0, saddr: '0, paddr: '0};
        m_reset();
        step();
        s.rst = 1'b1; step();
        idle(2);

        // Reset pulsed while a lookup is in its LOOKUP cycle.
        wr(2'd1, entry(1, 13'h1ABC, 8'h3C));
        idle(1);
        s.sreq = 1'b1; s.saddr = 13'h1ABC; step();
        s.sreq = 1'b0; s.rst = 1'b1; step();
        idle(4);
        si_lookup(13'h1ABC);

        wr(2'd0, entry(1, 13'h0000, 8'hA5));
        wr(2'd1, entry(1, 13'h1ABC, 8'h3C));
        idle(2);
        si_lookup(13'h1ABC);
        si_lookup(13'h0123);
        si_lookup(13'h0000);

        // Both requesters held: alternating grants.
        s.pat = 1'b1; s.sreq = 1'b1; s.preq = 1'b1;
        s.saddr = 13'h1ABC; s.paddr = 13'h0000;
        for (int i = 0; i < 13; i++) step();
        idle(3);

        // Pattern generator disabled.
        s.pat = 1'b0; s.sreq = 1'b1; s.preq = 1'b1;
        for (int i = 0; i < 10; i++) step();
        idle(3);
        s.pat = 1'b1;

        // Duplicate addresses and a rewrite during the LOOKUP cycle.
        wr(2'd0, entry(1, 13'h0040, 8'h11));
        wr(2'd2, entry(1, 13'h0040, 8'h22));
        idle(2);
        si_lookup(13'h0040);
        s.sreq = 1'b1; s.saddr = 13'h0040; step();
        s.sreq = 1'b0; s.we = 1'b1; s.idx = 2'd0; s.wd = entry(0, 13'h0040, 8'h11); step();
        step();
        si_lookup(13'h0040);

        // Index 3 ignored, then clear every enable.
        wr(2'd3, entry(1, 13'h0777, 8'h77));
        idle(1);
        si_lookup(13'h0777);
        wr(2'd0, '0);
        wr(2'd1, '0);
        wr(2'd2, '0);
        idle(3);

        // Random traffic, addresses drawn from a small pool so hits are frequent.
        pool[0] = 13'h0040; pool[1] = 13'h1ABC; pool[2] = 13'h0000; pool[3] = 13'h1FFF;
        for (int i = 0; i < 1500; i++) begin
            s.sreq  = ($urandom_range(0, 3) != 0);
            s.preq  = ($urandom_range(0, 3) != 0);
            s.saddr = pool[$urandom_range(0, 3)];
            s.paddr = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 19) == 0) s.pat = ~s.pat;
            if ($urandom_range(0, 4) == 0) begin
                s.we  = 1'b1;
                s.idx = 2'($urandom_range(0, 3));
                s.wd  = entry(($urandom_range(0, 2) != 0), pool[$urandom_range(0, 3)], 8'($urandom));
            end
            if ($urandom_range(0, 299) == 0) s.rst = 1'b1;
            step();
        end
        idle(4);

        check("grants_seen", (grant_count > 100), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
